// File: rtl/sap_ctrl_seq.sv
// sap_ctrl_seq: SAP-1 controller-sequencer.
// A one-hot T1..T6 ring runs fetch then execute for each instruction, and the
// current state plus the IR opcode are decoded into the datapath control word.
// Also owns the one-cycle synchronous clr pulse that follows reset release.
// Optional build macro SAP_EARLY_END_EN: the ring returns to T1 right after
// the last useful state of each instruction instead of always using six states.
module sap_ctrl_seq (
   input  logic       clk,
   input  logic       nclr,
   input  logic [3:0] opcode,
   output logic       clr,
   output logic       Cp,
   output logic       Ep,
   output logic       nLm,
   output logic       nCE,
   output logic       nLi,
   output logic       nEi,
   output logic       nLa,
   output logic       Ea,
   output logic       Su,
   output logic       Eu,
   output logic       nLb,
   output logic       nLo,
   output logic [5:0] t_state,
   output logic       hlt
);

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   // The ring encoding doubles as the t_state output; all-zero marks halt.
   typedef enum logic [5:0] {
      HALT = 6'b000000,
      T1   = 6'b000001,
      T2   = 6'b000010,
      T3   = 6'b000100,
      T4   = 6'b001000,
      T5   = 6'b010000,
      T6   = 6'b100000
   } tState_e;

   tState_e state_q, state_d;
   logic    clr_q;
   logic    hlt_q, hlt_d;

`ifdef SAP_EARLY_END_EN
   logic opKnown;
   assign opKnown = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_OUT) || (opcode == OP_HLT);
`endif

   // Ring, halt flag and clr pulse; reset aborts any instruction immediately.
   always_ff @(posedge clk or negedge nclr) begin
      if (!nclr) begin
         state_q <= T1;
         clr_q   <= 1'b1;
         hlt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         clr_q   <= 1'b0;
         hlt_q   <= hlt_d;
      end
   end

   // Next ring state: hold T1 during the clr cycle, freeze once halted, and
   // send any illegal encoding back to T1.
   always_comb begin
      state_d = state_q;
      hlt_d   = hlt_q;
      if (clr_q) begin
         state_d = T1;
      end else if (hlt_q) begin
         state_d = HALT;
      end else begin
         case (state_q)
            T1: state_d = T2;
            T2: state_d = T3;
`ifdef SAP_EARLY_END_EN
            T3: state_d = opKnown ? T4 : T1;
`else
            T3: state_d = T4;
`endif
            T4: begin
               if (opcode == OP_HLT) begin
                  state_d = HALT;
                  hlt_d   = 1'b1;
`ifdef SAP_EARLY_END_EN
               end else if (opcode == OP_OUT) begin
                  state_d = T1;
`endif
               end else begin
                  state_d = T5;
               end
            end
`ifdef SAP_EARLY_END_EN
            T5: state_d = (opcode == OP_LDA) ? T1 : T6;
`else
            T5: state_d = T6;
`endif
            T6: state_d = T1;
            default: state_d = T1;
         endcase
      end
   end

   // Control word decode; everything stays inactive during clr and halt.
   always_comb begin
      Cp  = 1'b0;
      Ep  = 1'b0;
      Ea  = 1'b0;
      Su  = 1'b0;
      Eu  = 1'b0;
      nLm = 1'b1;
      nCE = 1'b1;
      nLi = 1'b1;
      nEi = 1'b1;
      nLa = 1'b1;
      nLb = 1'b1;
      nLo = 1'b1;
      if (!clr_q && !hlt_q) begin
         case (state_q)
            T1: begin
               Ep  = 1'b1;
               nLm = 1'b0;
            end
            T2: Cp = 1'b1;
            T3: begin
               nCE = 1'b0;
               nLi = 1'b0;
            end
            T4: begin
               if ((opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB)) begin
                  nEi = 1'b0;
                  nLm = 1'b0;
               end else if (opcode == OP_OUT) begin
                  Ea  = 1'b1;
                  nLo = 1'b0;
               end
            end
            T5: begin
               if (opcode == OP_LDA) begin
                  nCE = 1'b0;
                  nLa = 1'b0;
               end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                  nCE = 1'b0;
                  nLb = 1'b0;
               end
            end
            T6: begin
               if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                  Eu  = 1'b1;
                  nLa = 1'b0;
                  Su  = (opcode == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

   assign clr     = clr_q;
   assign hlt     = hlt_q;
   assign t_state = state_q;

endmodule
